// File: rtl/byteswap_burst_sched.sv
// Splits a byteswap transfer into 4 KiB-safe read bursts, then issues the same write bursts in order.
// Latency: first read command two cycles after ap_start; ap_done one cycle after the last write response.
// Backpressure: command valid holds with stable addr/len until ready; reads stall once the outstanding-burst credit limit is reached.
module byteswap_burst_sched #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int C_MAX_BURST_BEATS = 64,
    parameter int C_MAX_OUTSTANDING = 4
) (
    input  logic                         ap_clk,
    input  logic                         areset,
    input  logic                         ap_start,
    output logic                         ap_idle,
    output logic                         ap_done,
    output logic                         ap_ready,
    input  logic [C_XFER_SIZE_WIDTH-1:0] xfer_size_bytes,
    input  logic [C_ADDR_WIDTH-1:0]      gmem_ptr,
    output logic                         rd_cmd_valid,
    input  logic                         rd_cmd_ready,
    output logic [C_ADDR_WIDTH-1:0]      rd_cmd_addr,
    output logic [7:0]                   rd_cmd_len,
    input  logic                         rd_done,
    output logic                         wr_cmd_valid,
    input  logic                         wr_cmd_ready,
    output logic [C_ADDR_WIDTH-1:0]      wr_cmd_addr,
    output logic [7:0]                   wr_cmd_len,
    input  logic                         wr_done
);

    localparam int BPB     = C_DATA_WIDTH / 8;
    localparam int LOG_BPB = $clog2(BPB);
    localparam int NW      = C_XFER_SIZE_WIDTH + 1;
    localparam int CW      = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [C_ADDR_WIDTH-1:0] r_rd_next_addr, r_wr_next_addr;
    logic [C_ADDR_WIDTH-1:0] r_rd_addr, r_wr_addr;
    logic [NW-1:0]           r_rd_rem, r_wr_rem;
    logic [7:0]              r_rd_len, r_wr_len;
    logic                    r_rd_vld, r_wr_vld;
    logic [CW-1:0]           r_rd_issued, r_rd_completed, r_wr_issued, r_wr_acked;

    logic                    w_start;
    logic [NW-1:0]           w_n;
    logic                    w_rd_fire, w_wr_fire;
    logic                    w_rd_done, w_wr_done;
    logic [CW-1:0]           w_rd_issued_nxt, w_rd_completed_nxt;
    logic [CW-1:0]           w_wr_issued_nxt, w_wr_acked_nxt;
    logic [NW-1:0]           w_rd_beats, w_wr_beats;
    logic                    w_rd_load, w_wr_load;

    // Beats in the next burst: limited by what is left, the burst cap and the next 4 KiB boundary.
    function automatic logic [NW-1:0] f_burst_beats(input logic [11:0] page_off,
                                                    input logic [NW-1:0] rem);
        logic [12:0]   to_page;
        logic [NW-1:0] beats;
        to_page = 13'd4096 - {1'b0, page_off};
        beats   = rem;
        if (beats > NW'(C_MAX_BURST_BEATS)) beats = NW'(C_MAX_BURST_BEATS);
        if (beats > NW'(to_page >> LOG_BPB)) beats = NW'(to_page >> LOG_BPB);
        return beats;
    endfunction

    assign w_start   = (r_state == S_IDLE) && ap_start;
    // One spare bit so an all-ones byte count cannot wrap when rounded up.
    assign w_n       = ({1'b0, xfer_size_bytes} + NW'(BPB - 1)) >> LOG_BPB;
    assign w_rd_fire = r_rd_vld && rd_cmd_ready;
    assign w_wr_fire = r_wr_vld && wr_cmd_ready;
    // Done pulses arriving while idle belong to nothing and are dropped.
    assign w_rd_done = rd_done && (r_state != S_IDLE);
    assign w_wr_done = wr_done && (r_state != S_IDLE);

    assign w_rd_issued_nxt    = r_rd_issued + CW'(w_rd_fire);
    assign w_rd_completed_nxt = r_rd_completed + CW'(w_rd_done);
    assign w_wr_issued_nxt    = r_wr_issued + CW'(w_wr_fire);
    assign w_wr_acked_nxt     = r_wr_acked + CW'(w_wr_done);

    assign w_rd_beats = f_burst_beats(r_rd_next_addr[11:0], r_rd_rem);
    assign w_wr_beats = f_burst_beats(r_wr_next_addr[11:0], r_wr_rem);

    // Credit is judged on post-update counters so a freed credit shows one cycle after wr_done.
    assign w_rd_load = ((r_state == S_INIT) || (r_state == S_RUN)) &&
                       (!r_rd_vld || rd_cmd_ready) && (r_rd_rem != '0) &&
                       ((w_rd_issued_nxt - w_wr_acked_nxt) < CW'(C_MAX_OUTSTANDING));
    // A write may only follow a read burst whose data has fully landed.
    assign w_wr_load = ((r_state == S_RUN) || (r_state == S_DRAIN)) &&
                       (!r_wr_vld || wr_cmd_ready) && (r_wr_rem != '0) &&
                       (w_wr_issued_nxt < w_rd_completed_nxt);

    assign rd_cmd_valid = r_rd_vld;
    assign rd_cmd_addr  = r_rd_addr;
    assign rd_cmd_len   = r_rd_len;
    assign wr_cmd_valid = r_wr_vld;
    assign wr_cmd_addr  = r_wr_addr;
    assign wr_cmd_len   = r_wr_len;

    // State register.
    always_ff @(posedge ap_clk) begin
        if (areset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs for the control slave.
    always_comb begin
        w_state_nxt = r_state;
        ap_idle     = 1'b0;
        ap_done     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) w_state_nxt = S_INIT;
            end
            S_INIT: begin
                // r_rd_rem holds the total beat count here.
                if (r_rd_rem == '0) w_state_nxt = S_DONE;
                else                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if ((r_rd_rem == '0) && (!r_rd_vld || rd_cmd_ready)) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // r_rd_issued is final here and equals the total burst count.
                if (w_wr_acked_nxt == r_rd_issued) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                ap_done     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign ap_ready = ap_done;

    // Burst bookkeeping counters, cleared when a transfer is accepted.
    always_ff @(posedge ap_clk) begin
        if (areset || w_start) begin
            r_rd_issued    <= '0;
            r_rd_completed <= '0;
            r_wr_issued    <= '0;
            r_wr_acked     <= '0;
        end else begin
            r_rd_issued    <= w_rd_issued_nxt;
            r_rd_completed <= w_rd_completed_nxt;
            r_wr_issued    <= w_wr_issued_nxt;
            r_wr_acked     <= w_wr_acked_nxt;
        end
    end

    // Read command generator: presents one burst at a time and holds it until accepted.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_rd_vld       <= 1'b0;
            r_rd_addr      <= '0;
            r_rd_len       <= '0;
            r_rd_next_addr <= '0;
            r_rd_rem       <= '0;
        end else if (w_start) begin
            r_rd_vld       <= 1'b0;
            r_rd_next_addr <= gmem_ptr;
            r_rd_rem       <= w_n;
        end else if (w_rd_load) begin
            r_rd_vld       <= 1'b1;
            r_rd_addr      <= r_rd_next_addr;
            r_rd_len       <= 8'(w_rd_beats - NW'(1));
            r_rd_next_addr <= r_rd_next_addr + (C_ADDR_WIDTH'(w_rd_beats) << LOG_BPB);
            r_rd_rem       <= r_rd_rem - w_rd_beats;
        end else if (w_rd_fire) begin
            r_rd_vld       <= 1'b0;
        end
    end

    // Write command generator: replays the identical burst walk, gated by completed reads.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_wr_vld       <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_len       <= '0;
            r_wr_next_addr <= '0;
            r_wr_rem       <= '0;
        end else if (w_start) begin
            r_wr_vld       <= 1'b0;
            r_wr_next_addr <= gmem_ptr;
            r_wr_rem       <= w_n;
        end else if (w_wr_load) begin
            r_wr_vld       <= 1'b1;
            r_wr_addr      <= r_wr_next_addr;
            r_wr_len       <= 8'(w_wr_beats - NW'(1));
            r_wr_next_addr <= r_wr_next_addr + (C_ADDR_WIDTH'(w_wr_beats) << LOG_BPB);
            r_wr_rem       <= r_wr_rem - w_wr_beats;
        end else if (w_wr_fire) begin
            r_wr_vld       <= 1'b0;
        end
    end

endmodule
